game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/tetris_pkg.sv | 28 ++
 rtl/drop_timer.sv | 24 ++
 rtl/game_sequencer.sv | 109 ++++++++++
 tb/tb_game_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared game states, playfield constants and drop-period helper
package tetris_pkg;

   localparam int         ROWS      = 20;
   localparam int         COLS      = 10;
   localparam logic [4:0] SQUARE_ID = 5'd1;

   typedef enum logic [2:0] {
      INIT     = 3'd0,
      SPAWN    = 3'd1,
      FALLING  = 3'd2,
      ROTATE   = 3'd3,
      STUCK    = 3'd4,
      LANDED   = 3'd5,
      EVAL     = 3'd6,
      GAMEOVER = 3'd7
   } game_state_t;

   // Gravity gets faster every ten cleared lines, saturating at level 7 and a period of 2.
   function automatic logic [31:0] speed_period(input logic [31:0] base, input logic [7:0] lines);
      logic [2:0]  level;
      logic [31:0] p;
      level = (lines >= 8'd70) ? 3'd7 : 3'(lines / 8'd10);
      p     = base >> level;
      return (p < 32'd2) ? 32'd2 : p;
   endfunction

endpackage

// File: rtl/drop_timer.sv
// rtl/drop_timer.sv - gravity counter producing a one-cycle tick every period cycles
module drop_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [31:0] period,
   output logic        tick
);

   logic [31:0] count;

   // Tick is gated by en so a paused counter sitting on its last value stays quiet.
   assign tick = en && (count == period - 32'd1);

   // Count while enabled, wrap on the tick, clear on request.
   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (en)
         count <= tick ? '0 : count + 32'd1;
   end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - falling-block game sequencer; GAME_SPEEDUP_EN enables level-based gravity
module game_sequencer
   import tetris_pkg::*;
#(
   parameter int unsigned DROP_PERIOD = 25000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             collision_bottom,
   input  logic             rotate_pulse,
   input  logic [4:0]       current_block_type,
   input  logic [19:0][9:0] stored_array,
   output logic [2:0]       current_state,
   output logic             drop_tick,
   output logic             spawn_o,
   output logic             lock_o,
   output logic             clear_valid_o,
   output logic [4:0]       clear_row_o,
   output logic             eval_complete,
   output logic [7:0]       lines_cleared,
   output logic             gameover_o
);

   game_state_t state;
   logic [4:0]  row_ptr;
   logic        clr_wait;
   logic [31:0] period;
   logic        row_full;

   assign row_full      = &stored_array[row_ptr];
   assign current_state = state;
   assign spawn_o       = (state == SPAWN);
   assign lock_o        = (state == LANDED);
   assign gameover_o    = (state == GAMEOVER);

`ifdef GAME_SPEEDUP_EN
   // Latch the level-adjusted period once per piece so a piece never changes speed mid-fall.
   always_ff @(posedge clk) begin
      if (rst)
         period <= 32'(DROP_PERIOD);
      else if (state == SPAWN)
         period <= speed_period(32'(DROP_PERIOD), lines_cleared);
   end
`else
   assign period = 32'(DROP_PERIOD);
`endif

   drop_timer u_drop_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (state == SPAWN),
      .en     (state == FALLING),
      .period (period),
      .tick   (drop_tick)
   );

   // Game flow plus the bottom-up line scan; a clear spends one extra cycle so the
   // playfield can shift before the same row is looked at again.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= INIT;
         row_ptr       <= '0;
         clr_wait      <= 1'b0;
         clear_valid_o <= 1'b0;
         clear_row_o   <= '0;
         eval_complete <= 1'b0;
         lines_cleared <= '0;
      end else begin
         clear_valid_o <= 1'b0;
         eval_complete <= 1'b0;
         case (state)
            INIT:     if (start_i) state <= SPAWN;
            SPAWN:    state <= FALLING;
            FALLING: begin
               if (collision_bottom)
                  state <= STUCK;
               else if (rotate_pulse && current_block_type != SQUARE_ID)
                  state <= ROTATE;
            end
            ROTATE:   state <= FALLING;
            STUCK:    state <= (|stored_array[0]) ? GAMEOVER : LANDED;
            LANDED: begin
               state    <= EVAL;
               row_ptr  <= 5'(ROWS - 1);
               clr_wait <= 1'b0;
            end
            EVAL: begin
               if (clr_wait) begin
                  clr_wait <= 1'b0;
               end else if (row_full) begin
                  clear_valid_o <= 1'b1;
                  clear_row_o   <= row_ptr;
                  lines_cleared <= lines_cleared + 8'd1;
                  clr_wait      <= 1'b1;
               end else if (row_ptr != 5'd0) begin
                  row_ptr <= row_ptr - 5'd1;
               end else begin
                  eval_complete <= 1'b1;
                  state         <= SPAWN;
               end
            end
            GAMEOVER: state <= GAMEOVER;
            default:  state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized self-checking bench for game_sequencer
`timescale 1ns/1ps
module tb_game_sequencer;
   import tetris_pkg::*;

`ifdef GAME_SPEEDUP_EN
   localparam int DP = 16;
`else
   localparam int DP = 4;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i;
   logic             collision_bottom;
   logic             rotate_pulse;
   logic [4:0]       current_block_type;
   logic [19:0][9:0] stored_array;
   logic [2:0]       current_state;
   logic             drop_tick;
   logic             spawn_o;
   logic             lock_o;
   logic             clear_valid_o;
   logic [4:0]       clear_row_o;
   logic             eval_complete;
   logic [7:0]       lines_cleared;
   logic             gameover_o;

   int vectors     = 0;
   int miscompares = 0;
   int lines_model = 0;

   always #5 clk = ~clk;

   game_sequencer #(.DROP_PERIOD(DP)) dut (
      .clk                (clk),
      .rst                (rst),
      .start_i            (start_i),
      .collision_bottom   (collision_bottom),
      .rotate_pulse       (rotate_pulse),
      .current_block_type (current_block_type),
      .stored_array       (stored_array),
      .current_state      (current_state),
      .drop_tick          (drop_tick),
      .spawn_o            (spawn_o),
      .lock_o             (lock_o),
      .clear_valid_o      (clear_valid_o),
      .clear_row_o        (clear_row_o),
      .eval_complete      (eval_complete),
      .lines_cleared      (lines_cleared),
      .gameover_o         (gameover_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_period(input int lines);
`ifdef GAME_SPEEDUP_EN
      int lvl;
      int p;
      lvl = (lines % 256) / 10;
      if (lvl > 7) lvl = 7;
      p = DP >> lvl;
      return (p < 2) ? 2 : p;
`else
      return DP + 0 * lines;
`endif
   endfunction

   function automatic logic [4:0] pulses();
      return {spawn_o, lock_o, clear_valid_o, eval_complete, gameover_o};
   endfunction

   task automatic do_reset();
      rst              = 1'b1;
      start_i          = 1'($urandom);
      rotate_pulse     = 1'($urandom);
      collision_bottom = 1'($urandom);
      @(negedge clk);
      check("rst_state", current_state, INIT);
      check("rst_pulses", {drop_tick, pulses()}, 6'b0);
      check("rst_lines", lines_cleared, 0);
      check("rst_row", clear_row_o, 0);
      rst              = 1'b0;
      start_i          = 1'b0;
      rotate_pulse     = 1'b0;
      collision_bottom = 1'b0;
      lines_model      = 0;
   endtask

   task automatic start_game();
      start_i = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("init_hold", current_state, INIT);
      end
      start_i = 1'b1;
      @(negedge clk);
      check("spawn_state", current_state, SPAWN);
      check("spawn_pulse", spawn_o, 1);
      start_i = 1'($urandom);
   endtask

   // mode 0: random clears, 1: game over, 2: reset mid-scan, 3: rows 18/19 full
   task automatic run_piece(input int mode);
      int               p_exp;
      int               fall_n;
      int               steps;
      int               i;
      int               nfull;
      int               k;
      int               ec;
      int               r;
      bit               done;
      bit               exp_tick;
      bit               dup;
      game_state_t      es;
      logic [19:0][9:0] field;
      int               full_rows[$];

      p_exp  = model_period(lines_model);
      fall_n = 0;
      steps  = $urandom_range(2, 4 * p_exp + 3);
      i      = 0;
      done   = 1'b0;
      es     = FALLING;
      collision_bottom = 1'b0;
      rotate_pulse     = 1'b0;
      @(negedge clk);
      while (!done) begin
         exp_tick = (es == FALLING) && (fall_n % p_exp == p_exp - 1);
         check("fall_state", current_state, es);
         check("drop_tick", drop_tick, exp_tick);
         check("fall_pulses", pulses(), 5'b0);
         if (es == FALLING) fall_n++;
         current_block_type = ($urandom_range(0, 2) == 0) ? 5'd1 : 5'($urandom_range(2, 31));
         rotate_pulse       = ($urandom_range(0, 2) == 0);
         start_i            = 1'($urandom);
         if (es == FALLING && i >= steps) begin
            collision_bottom = 1'b1;
            done             = 1'b1;
            field            = '0;
            full_rows.delete();
            nfull = (mode == 2) ? 0 : (mode == 3) ? 2 : $urandom_range(0, 4);
            for (int rr = 1; rr < 20; rr++)
               field[rr] = 10'($urandom) & ~(10'd1 << $urandom_range(0, 9));
            if (mode == 3) begin
               full_rows.push_back(19);
               full_rows.push_back(18);
            end
            while (full_rows.size() < nfull) begin
               r   = $urandom_range(1, 19);
               dup = 1'b0;
               foreach (full_rows[j]) if (full_rows[j] == r) dup = 1'b1;
               if (!dup) full_rows.push_back(r);
            end
            full_rows.rsort();
            foreach (full_rows[j]) field[full_rows[j]] = '1;
            if (mode == 1) field[0] = 10'b0000100000;
            stored_array = field;
            es = STUCK;
         end else if (es == FALLING) begin
            collision_bottom = 1'b0;
            es = (rotate_pulse && current_block_type != 5'd1) ? ROTATE : FALLING;
         end else begin
            collision_bottom = 1'($urandom);
            es = FALLING;
         end
         i++;
         @(negedge clk);
      end
      collision_bottom = 1'b0;
      check("stuck_state", current_state, STUCK);
      @(negedge clk);
      if (mode == 1) begin
         check("gameover_state", current_state, GAMEOVER);
         check("gameover_o", gameover_o, 1);
         start_i = 1'b1;
         repeat (4) begin
            rotate_pulse = 1'($urandom);
            @(negedge clk);
            check("gameover_hold", current_state, GAMEOVER);
            check("gameover_pulses", {drop_tick, pulses()}, 6'b000001);
         end
         do_reset();
         return;
      end
      check("landed_state", current_state, LANDED);
      check("lock_pulse", lock_o, 1);
      @(negedge clk);
      ec = 0;
      k  = 0;
      while (current_state == EVAL && ec < 60) begin
         check("eval_busy", eval_complete, 0);
         if (clear_valid_o) begin
            if (k < full_rows.size())
               check("clear_row", clear_row_o, full_rows[k] + k);
            else
               check("clear_extra", clear_valid_o, 0);
            k++;
            if (clear_row_o < 20) begin
               for (int rr = 19; rr > 0; rr--)
                  if (rr <= clear_row_o) stored_array[rr] = stored_array[rr-1];
               stored_array[0] = '0;
            end
         end
         if (mode == 2 && ec == 9) begin
            rst = 1'b1;
            @(negedge clk);
            check("abort_state", current_state, INIT);
            check("abort_pulses", {drop_tick, pulses()}, 6'b0);
            check("abort_lines", lines_cleared, 0);
            rst         = 1'b0;
            lines_model = 0;
            @(negedge clk);
            check("abort_quiet", pulses(), 5'b0);
            return;
         end
         ec++;
         @(negedge clk);
      end
      lines_model += nfull;
      check("eval_cycles", ec, 20 + 2 * nfull);
      check("clear_count", k, nfull);
      check("eval_done", eval_complete, 1);
      check("respawn_state", current_state, SPAWN);
      check("respawn_pulse", spawn_o, 1);
      check("lines_cleared", lines_cleared, lines_model % 256);
   endtask

   initial begin
      rst                = 1'b1;
      start_i            = 1'b0;
      collision_bottom   = 1'b0;
      rotate_pulse       = 1'b0;
      current_block_type = 5'd3;
      stored_array       = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset_state", current_state, INIT);
      check("reset_outputs", {drop_tick, pulses()}, 6'b0);
      check("reset_lines", lines_cleared, 0);
      check("reset_row", clear_row_o, 0);
      rst = 1'b0;
      start_game();
      for (int p = 0; p < 40; p++) begin
         run_piece((p == 0) ? 3 : (p == 12 || p == 30) ? 1 : (p == 20) ? 2 : 0);
         if (current_state == INIT) begin
            start_game();
         end else if (current_state != SPAWN) begin
            do_reset();
            start_game();
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
